dsp_chain_fp16_sop2_stream: RTL

Parametrised, flow-controlled chain of `NUM_STAGES` `fp16_sop2_mult_dspchain` instances that computes the fp32 sum over all stages of (top_a*top_b + bot_a*bot_b) once per accepted input beat. The block adds the following around the cascaded DSP chain:
- per-stage operand skew, so each stage lines up with its cascade input;
- a valid-tracking pipeline;
- an output FIFO with credit-based backpressure.

It sits between operand buffers and the accumulator/writeback logic of the dot-product datapath.

---
 rtl/dsp_chain_fp16_sop2_stream.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/dsp_chain_fp16_sop2_stream.sv
//----------------------------------------------------------------------------
// dsp_chain_fp16_sop2_stream : skewed, flow-controlled chain of fp16 SOP2 DSPs
// summing all stages into fp32, with a credit-guarded output FIFO.
// Optional perf counters: define DSP_CHAIN_PERF_CNT_EN.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fp16_sop2_mult_dspchain #(
  parameter int CHAIN_LAT = 1,
  parameter int DSP_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode_sigs,   // [0] addend = fp32_in, [1] negate bottom product
  input  logic [15:0] top_a,
  input  logic [15:0] top_b,
  input  logic [15:0] bot_a,
  input  logic [15:0] bot_b,
  input  logic [31:0] fp32_in,
  input  logic [31:0] chainin,
  output logic [31:0] chainout,
  output logic [31:0] result
);
  // fp16 x fp16 is exact in fp32; subnormal inputs flush to zero.
  function automatic logic [31:0] f16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] m;
    logic [8:0]  e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'h00 || b[14:10] == 5'h00) return {s, 31'h0};
    if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) return {s, 8'hFF, 23'h0};
    m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = 9'(a[14:10]) + 9'(b[14:10]) + 9'd97;
    if (m[21]) return {s, 8'(e + 9'd1), m[20:0], 2'b00};
    return {s, e[7:0], m[19:0], 3'b000};
  endfunction

  // fp32 add, round-to-nearest-even, subnormals flushed.
  function automatic logic [31:0] f32_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [49:0] t;
    logic [26:0] ax, bx;
    logic [27:0] s;
    logic [24:0] mr;
    int          e, d;
    if (x[30:23] == 8'h00) return y;
    if (y[30:23] == 8'h00) return x;
    if (y[30:0] > x[30:0]) begin a = y; b = x; end
    else begin a = x; b = y; end
    d = int'(a[30:23]) - int'(b[30:23]);
    if (d > 31) d = 31;
    t  = {1'b1, b[22:0], 26'h0} >> d;
    ax = {1'b1, a[22:0], 3'b000};
    bx = {t[49:24], |t[23:0]};
    e  = int'(a[30:23]);
    if (a[31] == b[31]) begin
      s = {1'b0, ax} + {1'b0, bx};
      if (s[27]) begin
        s = {1'b0, s[27:2], s[1] | s[0]};
        e = e + 1;
      end
    end else begin
      s = {1'b0, ax} - {1'b0, bx};
      if (s == '0) return 32'h0;
      for (int i = 0; i < 27; i++) begin
        if (!s[26]) begin
          s = s << 1;
          e = e - 1;
        end
      end
    end
    mr = {1'b0, s[26:3]};
    if (s[2] && (s[1] || s[0] || s[3])) mr = mr + 25'd1;
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 1;
    end
    if (e >= 255) return {a[31], 8'hFF, 23'h0};
    if (e <= 0)   return {a[31], 31'h0};
    return {a[31], 8'(e), mr[22:0]};
  endfunction

  logic [31:0] w_p_bot;
  logic [31:0] w_sum;
  logic [31:0] r_chain [CHAIN_LAT];
  logic [31:0] r_res   [DSP_LAT];

  assign w_p_bot = f16_mul(bot_a, bot_b) ^ {mode_sigs[1], 31'h0};
  assign w_sum   = f32_add(mode_sigs[0] ? fp32_in : chainin,
                           f32_add(f16_mul(top_a, top_b), w_p_bot));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHAIN_LAT; i++) r_chain[i] <= '0;
      for (int i = 0; i < DSP_LAT; i++)   r_res[i]   <= '0;
    end else begin
      r_chain[0] <= w_sum;
      r_res[0]   <= w_sum;
      for (int i = 1; i < CHAIN_LAT; i++) r_chain[i] <= r_chain[i-1];
      for (int i = 1; i < DSP_LAT; i++)   r_res[i]   <= r_res[i-1];
    end
  end

  assign chainout = r_chain[CHAIN_LAT-1];
  assign result   = r_res[DSP_LAT-1];
endmodule

module dsp_chain_fp16_sop2_stream #(
  parameter int NUM_STAGES = 4,
  parameter int CHAIN_LAT  = 1,
  parameter int DSP_LAT    = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [16*NUM_STAGES-1:0] top_a,
  input  logic [16*NUM_STAGES-1:0] top_b,
  input  logic [16*NUM_STAGES-1:0] bot_a,
  input  logic [16*NUM_STAGES-1:0] bot_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [31:0]             out_result
`ifdef DSP_CHAIN_PERF_CNT_EN
  ,
  output logic [31:0]             perf_results,
  output logic [31:0]             perf_stalls
`endif
);
  localparam int c_PIPE_LAT = (NUM_STAGES - 1) * CHAIN_LAT + DSP_LAT;
  localparam int c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int c_INF_W    = $clog2(c_PIPE_LAT + 1);
  localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(FIFO_DEPTH - 1);

  logic [31:0]          w_chain [NUM_STAGES+1];
  logic [31:0]          w_result;
  logic                 w_accept, w_push, w_pop;
  logic [c_INF_W-1:0]   w_inflight;
  logic [c_PIPE_LAT-1:0] r_vpipe;
  logic [31:0]          r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_CNT_W-1:0]   r_count;

  assign w_chain[0] = '0;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    logic [63:0] w_ops;
    logic [31:0] w_stage_res;
    if (k == 0) begin : g_direct
      assign w_ops = {top_a[15:0], top_b[15:0], bot_a[15:0], bot_b[15:0]};
    end else begin : g_skew
      // Free-running skew: the valid pipe decides which slices matter.
      logic [63:0] r_skew [k*CHAIN_LAT];
      always_ff @(posedge clk) begin
        r_skew[0] <= {top_a[16*k +: 16], top_b[16*k +: 16], bot_a[16*k +: 16], bot_b[16*k +: 16]};
        for (int j = 1; j < k*CHAIN_LAT; j++) r_skew[j] <= r_skew[j-1];
      end
      assign w_ops = r_skew[k*CHAIN_LAT-1];
    end

    fp16_sop2_mult_dspchain #(.CHAIN_LAT(CHAIN_LAT), .DSP_LAT(DSP_LAT)) u_dsp (
      .clk      (clk),
      .reset    (reset),
      .mode_sigs(2'b00),
      .top_a    (w_ops[63:48]),
      .top_b    (w_ops[47:32]),
      .bot_a    (w_ops[31:16]),
      .bot_b    (w_ops[15:0]),
      .fp32_in  (32'h0),
      .chainin  (w_chain[k]),
      .chainout (w_chain[k+1]),
      .result   (w_stage_res)
    );

    if (k == NUM_STAGES - 1) begin : g_last
      assign w_result = w_stage_res;
    end else begin : g_mid
      logic [31:0] w_res_unused;
      assign w_res_unused = w_stage_res;
    end
  end

  logic [31:0] w_chain_tail_unused;
  assign w_chain_tail_unused = w_chain[NUM_STAGES];

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_PIPE_LAT; i++) w_inflight = w_inflight + c_INF_W'(r_vpipe[i]);
  end

  // Credits cover every in-flight beat, so a push always finds a free slot.
  assign in_ready   = (32'(w_inflight) + 32'(r_count)) < FIFO_DEPTH;
  assign w_accept   = in_valid && in_ready;
  assign w_push     = r_vpipe[c_PIPE_LAT-1];
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_ready && out_valid;
  assign out_result = out_valid ? r_mem[r_rd_ptr] : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vpipe  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_vpipe[0] <= w_accept;
      for (int i = 1; i < c_PIPE_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_result;
  end

`ifdef DSP_CHAIN_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_results <= '0;
      perf_stalls  <= '0;
    end else begin
      if (w_pop)                  perf_results <= perf_results + 32'd1;
      if (in_valid && !in_ready)  perf_stalls  <= perf_stalls + 32'd1;
    end
  end
`endif
endmodule

`default_nettype wire
